// File: rtl/pc_pkg.sv
// Shared definitions for the branch sequencer: command encodings and FSM state type.
package pc_pkg;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_JMP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// Command channel into the branch sequencer.
// A command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
// cmd_valid while cmd_ready is 0 is simply held off and nothing is consumed.
interface branch_sequencer_if #(
    parameter int COUNT_WIDTH = 8
);

    logic                   cmd_valid;
    logic [1:0]             cmd_op;
    logic [COUNT_WIDTH-1:0] cmd_target;
    logic                   cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_target, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_target, output cmd_ready);

endinterface

// File: rtl/return_stack.sv
// LIFO return-address stack; reset clears only the pointer, so old entries become unreachable.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    ptr;
    logic [AW-1:0]    top_idx;

    assign full    = (ptr == DW'(DEPTH));
    assign empty   = (ptr == '0);
    assign depth   = ptr;
    assign top_idx = AW'(ptr - DW'(1));
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + DW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: decodes JMP/CALL/RET into a one-cycle program-counter load,
// then spends ISSUE and SETTLE before taking the next command.
module branch_sequencer
    import pc_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COUNT_WIDTH-1:0]       count,
    branch_sequencer_if.slave            cmd,
    output logic                         set,
    output logic [COUNT_WIDTH-1:0]       set_value,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output seq_state_t                   state
);

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [COUNT_WIDTH-1:0] top_value;
    logic [COUNT_WIDTH-1:0] ret_addr;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign accept        = cmd.cmd_valid && (state == ST_IDLE);
    assign push          = accept && (cmd.cmd_op == OP_CALL) && !full;
    assign pop           = accept && (cmd.cmd_op == OP_RET) && !empty;
    // Return address wraps naturally at the top of the count range.
    assign ret_addr      = count + COUNT_WIDTH'(1);

    return_stack #(
        .WIDTH (COUNT_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (top_value),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            set           <= 1'b0;
            set_value     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            set <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd.cmd_op)
                            OP_NOP: ;
                            OP_JMP: begin
                                set_value <= cmd.cmd_target;
                                set       <= 1'b1;
                                state     <= ST_ISSUE;
                            end
                            OP_CALL: begin
                                if (!full) begin
                                    set_value <= cmd.cmd_target;
                                    set       <= 1'b1;
                                    state     <= ST_ISSUE;
                                end else begin
                                    err_overflow <= 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (!empty) begin
                                    set_value <= top_value;
                                    set       <= 1'b1;
                                    state     <= ST_ISSUE;
                                end else begin
                                    err_underflow <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_ISSUE:  state <= ST_SETTLE;
                ST_SETTLE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_branch_sequencer;
  import pc_pkg::*;

  localparam int CW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] count = '0;
  logic          set;
  logic [CW-1:0] set_value;
  logic [DW-1:0] depth;
  logic          err_overflow;
  logic          err_underflow;
  seq_state_t    state;

  branch_sequencer_if #(.COUNT_WIDTH(CW)) cmd ();

  branch_sequencer #(.COUNT_WIDTH(CW), .STACK_DEPTH(SD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .count         (count),
    .cmd           (cmd),
    .set           (set),
    .set_value     (set_value),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .state         (state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: a redirect costs three cycles, the stack is a plain queue
  logic [CW-1:0] m_stk[$];
  logic          m_set;
  logic [CW-1:0] m_val;
  logic          m_ovf;
  logic          m_unf;
  int            m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stk.delete();
      m_set = 1'b0;
      m_val = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_busy = 0;
    end else begin
      m_set = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (cmd.cmd_valid) begin
        case (cmd.cmd_op)
          2'd1: begin
            m_set = 1'b1; m_val = cmd.cmd_target; m_busy = 2;
          end
          2'd2: begin
            if (m_stk.size() < SD) begin
              m_stk.push_back(CW'(count + 1));
              m_set = 1'b1; m_val = cmd.cmd_target; m_busy = 2;
            end else begin
              m_ovf = 1'b1;
            end
          end
          2'd3: begin
            if (m_stk.size() > 0) begin
              m_val = m_stk.pop_back();
              m_set = 1'b1; m_busy = 2;
            end else begin
              m_unf = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_set",       32'(set),           32'(m_set));
      check("cyc_set_value", 32'(set_value),     32'(m_val));
      check("cyc_depth",     32'(depth),         32'(m_stk.size()));
      check("cyc_overflow",  32'(err_overflow),  32'(m_ovf));
      check("cyc_underflow", 32'(err_underflow), 32'(m_unf));
      check("cyc_ready",     32'(cmd.cmd_ready), 32'(m_busy == 0));
    end
  end

  // driver: offer a command, hold it until accepted, drop it just after the edge
  task automatic send(input logic [1:0] op, input logic [CW-1:0] tgt, input logic [CW-1:0] cnt);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = op;
    cmd.cmd_target = tgt;
    count          = cnt;
    while (!cmd.cmd_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd.cmd_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: cmd_ready got 0 after 8 cycles, expected 1");
    end
    @(posedge clk);
    #1 cmd.cmd_valid = 1'b0;
  endtask

  int pulses;

  initial begin
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = 2'd1;
    cmd.cmd_target = 8'h40;
    count          = 8'h10;

    // reset values held while rst_n is low, even with a command offered
    #12;
    check("rst_set",       32'(set), 0);
    check("rst_set_value", 32'(set_value), 0);
    check("rst_depth",     32'(depth), 0);
    check("rst_overflow",  32'(err_overflow), 0);
    check("rst_underflow", 32'(err_underflow), 0);
    check("rst_ready",     32'(cmd.cmd_ready), 1);
    check("rst_state",     32'(state), 32'(ST_IDLE));

    // JMP 0x40 taken on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 cmd.cmd_valid = 1'b0;
    @(negedge clk);
    check("jmp_set",   32'(set), 1);
    check("jmp_value", 32'(set_value), 32'h40);
    check("jmp_ready0", 32'(cmd.cmd_ready), 0);
    check("jmp_depth", 32'(depth), 0);
    @(negedge clk);
    check("jmp_set_drop", 32'(set), 0);
    check("jmp_ready1", 32'(cmd.cmd_ready), 0);
    @(negedge clk);
    check("jmp_ready_back", 32'(cmd.cmd_ready), 1);
    check("jmp_value_hold", 32'(set_value), 32'h40);

    // CALL 0x80 at 0x05, then RET returns 0x06
    send(2'd2, 8'h80, 8'h05);
    @(negedge clk);
    check("call_value", 32'(set_value), 32'h80);
    check("call_depth", 32'(depth), 1);
    send(2'd3, 8'h00, 8'h80);
    @(negedge clk);
    check("ret_value", 32'(set_value), 32'h06);
    check("ret_depth", 32'(depth), 0);

    // return address wraps: CALL at 0xFF pushes 0x00
    send(2'd2, 8'h33, 8'hFF);
    @(negedge clk);
    check("wrap_call_value", 32'(set_value), 32'h33);
    send(2'd3, 8'h00, 8'h33);
    @(negedge clk);
    check("wrap_ret_set",   32'(set), 1);
    check("wrap_ret_value", 32'(set_value), 32'h00);

    // fill the stack, overflow on the fifth CALL, then unwind LIFO
    for (int i = 0; i < 4; i++) begin
      send(2'd2, CW'(8'h11 + i), CW'(8'h20 + 8'h10 * i));
      @(negedge clk);
      check("fill_depth", 32'(depth), 32'(i + 1));
    end
    send(2'd2, 8'h15, 8'h60);
    @(negedge clk);
    check("ovf_set",   32'(set), 0);
    check("ovf_flag",  32'(err_overflow), 1);
    check("ovf_ready", 32'(cmd.cmd_ready), 1);
    check("ovf_depth", 32'(depth), 4);
    check("ovf_value_hold", 32'(set_value), 32'h14);
    for (int i = 0; i < 4; i++) begin
      send(2'd3, 8'h00, 8'h00);
      @(negedge clk);
      check("unwind_value", 32'(set_value), 32'(8'h51 - 8'h10 * i));
      check("unwind_depth", 32'(depth), 32'(3 - i));
    end

    // RET on empty stack, then NOP
    send(2'd3, 8'h00, 8'h00);
    @(negedge clk);
    check("unf_set",   32'(set), 0);
    check("unf_flag",  32'(err_underflow), 1);
    check("unf_ready", 32'(cmd.cmd_ready), 1);
    send(2'd0, 8'h77, 8'h00);
    @(negedge clk);
    check("nop_set",   32'(set), 0);
    check("nop_ovf",   32'(err_overflow), 1);
    check("nop_unf",   32'(err_underflow), 1);
    check("nop_ready", 32'(cmd.cmd_ready), 1);
    check("nop_value", 32'(set_value), 32'h21);

    // cmd_valid held through ISSUE/SETTLE must give one redirect only
    @(negedge clk);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = 2'd1;
    cmd.cmd_target = 8'h22;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (set) pulses++;
    end
    cmd.cmd_valid = 1'b0;
    @(negedge clk);
    if (set) pulses++;
    check("hold_pulses", 32'(pulses), 1);
    check("hold_value",  32'(set_value), 32'h22);

    // short reset pulse while set is high
    send(2'd2, 8'h90, 8'h07);
    @(negedge clk);
    check("pre_rst_set", 32'(set), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_set",   32'(set), 0);
    check("midrst_depth", 32'(depth), 0);
    check("midrst_ovf",   32'(err_overflow), 0);
    check("midrst_unf",   32'(err_underflow), 0);
    check("midrst_ready", 32'(cmd.cmd_ready), 1);
    check("midrst_value", 32'(set_value), 0);
    rst_n = 1'b1;
    send(2'd3, 8'h00, 8'h00);
    @(negedge clk);
    check("post_rst_ret_set", 32'(set), 0);
    check("post_rst_unf",     32'(err_underflow), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 8, SHALL set the width of count, cmd_target and set_value.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries (power of two, >=2).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port count  input  COUNT_WIDTH  SHALL carry the current program-counter value.
REQ-006 Port cmd_valid  input  1  SHALL indicate that a command is offered.
REQ-007 Port cmd_op  input  2  SHALL encode the command: 0 NOP, 1 JMP, 2 CALL, 3 RET.
REQ-008 Port cmd_target  input  COUNT_WIDTH  SHALL carry the destination for JMP/CALL; it is ignored otherwise.
REQ-009 Port cmd_ready  output  1  SHALL indicate that a command is accepted this cycle.
REQ-010 Port set  output  1  SHALL be a registered one-cycle load strobe to the program counter.
REQ-011 Port set_value  output  COUNT_WIDTH  SHALL be the registered load value, valid while set=1.
REQ-012 Port depth  output  clog2(STACK_DEPTH)+1  SHALL give the current return-stack occupancy.
REQ-013 Ports err_overflow and err_underflow  output  1 each  SHALL be sticky error flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and SETTLE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_valid while not ready SHALL be ignored and not consumed.
REQ-016 An accepted JMP SHALL move the FSM IDLE->ISSUE and load set_value with cmd_target.
REQ-017 An accepted CALL with depth<STACK_DEPTH SHALL push (count+1) mod 2^COUNT_WIDTH, load set_value with cmd_target and enter ISSUE.
REQ-018 An accepted RET with depth>0 SHALL pop the top entry into set_value and enter ISSUE.
REQ-019 In ISSUE, set SHALL be 1 for exactly one cycle; the FSM SHALL then move ISSUE->SETTLE->IDLE unconditionally, with set=0 in SETTLE.
REQ-020 Latency: for a command accepted at edge k, set SHALL be high between edges k and k+1, and cmd_ready SHALL be high again after edge k+2 (one redirect per 3 cycles).
REQ-021 set_value SHALL hold its last value until the next redirect.
REQ-022 An accepted NOP SHALL be consumed with no state change, and the FSM SHALL stay in IDLE.
REQ-023 A CALL with depth==STACK_DEPTH SHALL be consumed with no push and no set, SHALL set err_overflow, and the FSM SHALL stay in IDLE.
REQ-024 A RET with depth==0 SHALL be consumed with no pop and no set, SHALL set err_underflow, and the FSM SHALL stay in IDLE.
REQ-025 Error flags SHALL clear only on reset.
REQ-026 Push and pop SHALL never occur in the same cycle.
REQ-027 The stack SHALL be strictly LIFO.

Reset
REQ-028 While rst_n=0, the outputs SHALL be held as follows, independent of clk: set=0, set_value=0, depth=0, err_overflow=0, err_underflow=0, state=IDLE and cmd_ready=1.
REQ-029 Asserting reset mid-ISSUE SHALL drop set immediately and discard the redirect; stack contents SHALL be invalidated.
REQ-030 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package pc_pkg SHALL hold the op encodings (OP_NOP, OP_JMP, OP_CALL, OP_RET) and the FSM state type.
REQ-032 The return stack SHALL be one sub-module, return_stack (LIFO: push, pop, data in/out, depth, full, empty).
REQ-033 The top level SHALL contain only the FSM, the command decode and the error flags.

Verification
REQ-034 Reset, then JMP target=0x40 at count=0x10 -> set=1 for 1 cycle, set_value=0x40, cmd_ready low 2 cycles, depth=0.
REQ-035 CALL 0x80 at count=0x05, then RET -> the first set_value is 0x80, depth 1 then 0, the second set_value is 0x06.
REQ-036 CALL at count=0xFF -> pushed entry 0x00; the following RET gives set_value=0x00.
REQ-037 Five CALLs, each after the previous completes -> depth saturates at 4, the fifth gives no set, err_overflow=1; four RETs then return the pushed values in reverse order.
REQ-038 RET with an empty stack -> no set, err_underflow=1, cmd_ready stays 1; NOP -> no set, no flag change.
REQ-039 rst_n low for 1 ns while set=1 -> set=0 immediately, depth=0, flags 0; cmd_valid held high during ISSUE/SETTLE is not double-accepted.
